// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding and a two's-complement magnitude helper.
package mdu_pkg;

   // Widest operand the magnitude helper handles.
   localparam int MDU_MAX_W = 64;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } mdu_state_e;

   // Magnitude of a sign-extended two's-complement value. The most negative
   // narrow value maps to its positive counterpart because the input is
   // sign-extended first.
   function automatic logic [MDU_MAX_W-1:0] twos_mag(input logic [MDU_MAX_W-1:0] x);
      return x[MDU_MAX_W-1] ? -x : x;
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the pipeline (master) and the MDU (slave).
interface mdu_iter_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [2:0]        op;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              flush;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (output start, op, a, b, flush, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// does not go negative. A zero divisor always "succeeds", which yields an
// all-ones quotient and the dividend as remainder.
module mdu_div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem,
   input  logic [DATA_W-1:0] divisor,
   input  logic              dvd_bit,
   output logic [DATA_W-1:0] rem_next,
   output logic              q_bit
);
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   assign shifted  = {rem, dvd_bit};
   assign diff     = shifted - {1'b0, divisor};
   assign q_bit    = (shifted >= {1'b0, divisor});
   assign rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Optional build macro: MDU_EARLY_OUT_EN (multiplies finish early once the
// remaining multiplier bits are all zero; results are unchanged).
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO write here directly
// CALC  | one shift-add or restoring-divide step per cycle
// FIN   | sign correction, hi/lo written on leaving this state
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input logic       clk,
   input logic       rst_n,
   mdu_iter_if.slave bus
);
   localparam int              CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

   mdu_state_e          state, state_n;
   logic                busy;
   logic [2*DATA_W-1:0] acc;    // product accumulator / remainder in low half
   logic [2*DATA_W-1:0] mcd;    // shifting multiplicand / divisor in low half
   logic [DATA_W-1:0]   mpq;    // multiplier / dividend-then-quotient
   logic [CNT_W-1:0]    cnt;
   logic                is_div, neg_q, neg_r;
   logic [DATA_W-1:0]   hi_r, lo_r;
   logic                done_r;

   logic                req, accept, mt_hi, mt_lo, calc_step, early_out;
   logic                op_signed;
   logic [DATA_W-1:0]   mag_a, mag_b;
   logic [DATA_W-1:0]   div_rem;
   logic                div_q;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   quot, remd;

   assign req    = (state == IDLE) && bus.start && !bus.flush;
   assign accept = req && !bus.op[2];
   assign mt_hi  = req && (bus.op == MDU_MTHI);
   assign mt_lo  = req && (bus.op == MDU_MTLO);

   // Divide by zero is run unsigned so the raw dividend lands in hi.
   assign op_signed = (bus.op == MDU_MULT) || ((bus.op == MDU_DIV) && (bus.b != '0));
   assign mag_a = op_signed ? DATA_W'(twos_mag(MDU_MAX_W'($signed(bus.a)))) : bus.a;
   assign mag_b = op_signed ? DATA_W'(twos_mag(MDU_MAX_W'($signed(bus.b)))) : bus.b;

   assign calc_step = (state == CALC) && !bus.flush && (cnt != CNT_LAST);

`ifdef MDU_EARLY_OUT_EN
   assign early_out = !is_div && (mpq == '0);
`else
   assign early_out = 1'b0;
`endif

   mdu_div_step #(.DATA_W(DATA_W)) u_div_step (
      .rem      (acc[DATA_W-1:0]),
      .divisor  (mcd[DATA_W-1:0]),
      .dvd_bit  (mpq[DATA_W-1]),
      .rem_next (div_rem),
      .q_bit    (div_q)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // FSM next state and busy
   always_comb begin
      state_n = state;
      busy    = 1'b0;
      case (state)
         IDLE: if (accept) state_n = CALC;
         CALC: begin
            busy = 1'b1;
            if (bus.flush)             state_n = IDLE;
            else if (cnt == CNT_LAST)  state_n = FIN;
         end
         FIN: begin
            busy    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Operand capture and one iteration per CALC cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcd    <= '0;
         mpq    <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (accept) begin
         is_div <= bus.op[1];
         neg_q  <= op_signed && (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
         neg_r  <= op_signed && bus.a[DATA_W-1];
         acc    <= '0;
         cnt    <= '0;
         if (bus.op[1]) begin
            mcd <= {{DATA_W{1'b0}}, mag_b};
            mpq <= mag_a;
         end else begin
            mcd <= {{DATA_W{1'b0}}, mag_a};
            mpq <= mag_b;
         end
      end else if (calc_step && early_out) begin
         cnt <= CNT_LAST;
      end else if (calc_step) begin
         cnt <= cnt + CNT_W'(1);
         if (is_div) begin
            acc <= {{DATA_W{1'b0}}, div_rem};
            mpq <= {mpq[DATA_W-2:0], div_q};
         end else begin
            if (mpq[0]) acc <= acc + mcd;
            mcd <= mcd << 1;
            mpq <= mpq >> 1;
         end
      end
   end

   assign prod = neg_q ? -acc : acc;
   assign quot = neg_q ? -mpq : mpq;
   assign remd = neg_r ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];

   // Architectural HI/LO and the completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
      end else begin
         done_r <= (state == FIN) && !bus.flush;
         if (mt_hi) hi_r <= bus.a;
         if (mt_lo) lo_r <= bus.a;
         if ((state == FIN) && !bus.flush) begin
            hi_r <= is_div ? remd : prod[2*DATA_W-1:DATA_W];
            lo_r <= is_div ? quot : prod[DATA_W-1:0];
         end
      end
   end

   assign bus.busy = busy;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, hand-written
// flush/reset/handshake sequences and randomized ops against an arithmetic
// reference model.
module tb_mdu_iter;
   import mdu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   mdu_iter_if #(.DATA_W(32)) bus ();

   mdu_iter #(.DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   // Reference: {hi, lo} from plain integer arithmetic.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = '0;
      case (op)
         MDU_MULT:  res = 64'(sa * sb);
         MDU_MULTU: res = {32'd0, a} * {32'd0, b};
         MDU_DIV: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         MDU_DIVU: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else            res = {a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one MULT*/DIV* and wait for done; returns in the done cycle so a
   // following call starts back-to-back.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string name);
      int n;
      int bcnt;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
      check({name, "_done_low_after_start"}, 64'(bus.done), 64'd0);
      n    = 0;
      bcnt = 0;
      while (!bus.done && n < 100) begin
         if (bus.busy) bcnt++;
         tick();
         n++;
      end
`ifdef MDU_EARLY_OUT_EN
      if (op[1]) check({name, "_latency"}, 64'(n), 64'd34);
`else
      check({name, "_latency"}, 64'(n), 64'd34);
      check({name, "_busy_cycles"}, 64'(bcnt), 64'd34);
`endif
      check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      check({name, "_hilo"}, {bus.hi, bus.lo}, exp);
   endtask

   task automatic mt_write(input logic [2:0] op, input logic [31:0] a);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[12];
      logic [31:0] corner[5];
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      int          seen;

      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      bus.flush = 1'b0;

      vecs[0]  = '{MDU_MULT,  32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
      vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9,  32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
      vecs[3]  = '{MDU_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
      vecs[4]  = '{MDU_DIVU,  32'd100,        32'd0,         64'h0000_0064_FFFF_FFFF};
      vecs[5]  = '{MDU_DIV,   32'hFFFF_FFF9,  32'd0,         64'hFFFF_FFF9_FFFF_FFFF};
      vecs[6]  = '{MDU_DIV,   32'd7,          32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
      vecs[7]  = '{MDU_MULT,  32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
      vecs[8]  = '{MDU_DIVU,  32'hFFFF_FFFF,  32'h10,        64'h0000_000F_0FFF_FFFF};
      vecs[9]  = '{MDU_MULTU, 32'd0,          32'h1234_5678, 64'h0};
      vecs[10] = '{MDU_MULT,  32'hFFFF_FFFF,  32'd0,         64'h0};
      vecs[11] = '{MDU_DIV,   32'hFFFF_FFF9,  32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003};

      corner[0] = 32'd0;
      corner[1] = 32'd1;
      corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h8000_0000;
      corner[4] = 32'h7FFF_FFFF;

      // Reset values
      repeat (2) tick();
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_hi",   64'(bus.hi),   64'd0);
      check("reset_lo",   64'(bus.lo),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // MTHI / MTLO: single-edge writes, no busy, no done
      mt_write(MDU_MTHI, 32'h1234);
      check("mthi_hi",   64'(bus.hi),   64'h1234);
      check("mthi_busy", 64'(bus.busy), 64'd0);
      check("mthi_done", 64'(bus.done), 64'd0);
      mt_write(MDU_MTLO, 32'h5678);
      check("mtlo_lo",   64'(bus.lo),   64'h5678);
      check("mtlo_done", 64'(bus.done), 64'd0);

      // DIVU 9/4, start ignored while busy, flush mid-CALC
      bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd9; bus.b = 32'd4;
      tick();
      bus.start = 1'b0;
      check("divu_busy_after_start", 64'(bus.busy), 64'd1);
      repeat (5) tick();
      mt_write(MDU_MTLO, 32'hDEAD);
      check("start_while_busy_lo", 64'(bus.lo), 64'h5678);
      check("start_while_busy_busy", 64'(bus.busy), 64'd1);
      repeat (3) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush_calc_busy", 64'(bus.busy), 64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) seen++;
         tick();
      end
      check("flush_calc_no_done", 64'(seen), 64'd0);
      check("flush_calc_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);

      // Flush while in FIN
      bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd100; bus.b = 32'd7;
      tick();
      bus.start = 1'b0;
      repeat (33) tick();
      check("fin_busy_before_flush", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush_fin_busy", 64'(bus.busy), 64'd0);
      check("flush_fin_done", 64'(bus.done), 64'd0);
      tick();
      check("flush_fin_done_late", 64'(bus.done), 64'd0);
      check("flush_fin_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);

      // Flush in IDLE beats a simultaneous MTHI
      bus.flush = 1'b1;
      mt_write(MDU_MTHI, 32'hBEEF);
      bus.flush = 1'b0;
      check("flush_idle_mthi", 64'(bus.hi), 64'h1234);

      // Reserved op codes are no-ops
      for (int k = 6; k < 8; k++) begin
         mt_write(3'(k), 32'hCAFE);
         check("reserved_op_busy", 64'(bus.busy), 64'd0);
         check("reserved_op_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);
      end

      // Directed vector table (back-to-back)
      foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, "vec");
      tick();
      check("done_one_cycle", 64'(bus.done), 64'd0);

      // Randomized ops against the reference model
      for (int i = 0; i < 150; i++) begin
         rop = 3'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = 32'($signed($urandom_range(0, 40)) - 20); rb = 32'($signed($urandom_range(0, 10)) - 5); end
            2: begin ra = corner[$urandom_range(0, 4)]; rb = corner[$urandom_range(0, 4)]; end
            default: begin ra = $urandom; rb = 32'($urandom_range(0, 300)); end
         endcase
         run_op(rop, ra, rb, model(rop, ra, rb), "rand");
      end

      // Asynchronous reset in the middle of a multiply
      mt_write(MDU_MTHI, 32'hAAAA);
      mt_write(MDU_MTLO, 32'h5555);
      bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'h1234; bus.b = 32'h5678;
      tick();
      bus.start = 1'b0;
      repeat (15) tick();
      rst_n = 1'b0;
      #1;
      check("midop_reset_busy", 64'(bus.busy), 64'd0);
      check("midop_reset_done", 64'(bus.done), 64'd0);
      check("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_op(MDU_MULT, 32'd3, 32'd4, 64'd12, "post_reset_mult");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
